std_mem_arbiter: RTL
====================

Name: std_mem_arbiter

Overview:
- Shares one std_mem_intf command/result port pair of a single-cycle memory (e.g. one side of the dual-port block RAM wrapper) among NUM_REQUESTERS independent requesters.
- Round-robin arbitration onto a registered command output.
- Records the granted requester index for every read in an in-order tag FIFO, and steers each memory result back to the requester that issued the read.
- Writes produce no result and are not tracked.

Parameters:
- NUM_REQUESTERS, 2, number of requester command/result pairs; legal range 2..8.
- OUTSTANDING_DEPTH, 4, maximum reads in flight between command_out acceptance and result_in completion; power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- command_in[NUM_REQUESTERS]  std_mem_intf.in  intf  requester commands (valid, ready, read_enable, write_enable, addr, data, id).
- result_out[NUM_REQUESTERS]  std_mem_intf.out  intf  per-requester read results (valid, ready, data, id).
- command_out  std_mem_intf.out  intf  arbitrated command stream to the memory.
- result_in  std_mem_intf.in  intf  result stream from the memory; in-order, reads only.
- All interfaces have matching addr/data/id widths, checked by static assertion.

Behaviour:
- Reset values:
  - command_out.valid=0; all result_out[i].valid=0; all command_in[i].ready=0.
  - Round-robin pointer=0; tag FIFO empty (count=0).
- Arbitration:
  - Combinational. Scan requesters starting at the pointer, wrapping modulo NUM_REQUESTERS.
  - A requester is eligible when command_in[i].valid=1 and either read_enable=0 or tag FIFO count < OUTSTANDING_DEPTH.
  - The first eligible requester wins.
  - Only the winner sees ready=1, and only when the command register can load (command_out.valid=0 or command_out.ready=1).
- On acceptance (winner valid && ready):
  - Load read_enable, write_enable, addr, data, id into the command register; command_out.valid<=1.
  - Pointer <= winner+1 (wrap to 0 past NUM_REQUESTERS-1).
  - If read_enable, push the winner index into the tag FIFO.
  - Latency: command_in accept to command_out.valid is 1 cycle.
- Command register:
  - Holds its contents while command_out.valid && !command_out.ready.
  - Clears valid when accepted and no new winner exists.
- Tag FIFO capacity:
  - Count covers entries in the register and in the memory.
  - Full (count==OUTSTANDING_DEPTH) blocks read commands only; writes still pass.
  - A simultaneous pop does not unblock a read in the same cycle; eligibility uses the registered count.
- Result routing (combinational, 0-cycle):
  - FIFO head h selects the destination: result_out[h].valid=result_in.valid, with data and id passed through.
  - All other result_out valid=0.
  - result_in.ready=result_out[h].ready.
  - On result_in.valid && ready, pop the FIFO.
- Error cases:
  - result_in.valid with the FIFO empty: result_in.ready=1, the result is dropped, and a simulation-only assertion fires.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo OUTSTANDING_DEPTH.
- Reset mid-operation:
  - Any buffered command and all tags are discarded.
  - The memory is reset on the same rst, so no orphan results are expected.
- No combinational path from command_out.ready to result_out, or from result_out ready to command_in ready.

Optional Feature:
- Macro: STD_MEM_ARBITER_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed, and requester 0 can starve the others.
- Undefined: round-robin as above.

Test Plan:
- Requesters 0..2 all present reads to addr 0x10,0x20,0x30 every cycle, with command_out.ready=1 and a 1-cycle memory → grants in order 0,1,2,0,...; each result_out[i] returns the data for its own address with its id.
- OUTSTANDING_DEPTH=4, result_in held invalid, requester 1 issues 6 reads → 4 accepted; command_in[1].ready=0 afterwards. A write from requester 0 is still accepted. After 1 result pops, one more read is accepted the next cycle.
- command_out.ready=0 for 3 cycles with a command loaded → command_out fields are stable, and all command_in ready=0 during the stall.
- Result for requester 2 with result_out[2].ready=0 for 2 cycles → result_in.ready=0, FIFO not popped; a later result for requester 0 waits behind it.
- Assert rst with 3 reads in flight → next cycle all valids are 0 and count=0; first post-reset grant goes to requester 0.
- Build with STD_MEM_ARBITER_FIXED_PRIORITY_EN, requesters 0 and 3 continuously valid → requester 0 granted every cycle; 3 is granted only after 0 drops valid.

Source files
------------

// File: rtl/std_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// std_mem_intf
//
// Command/result bundle shared by the memory blocks and the arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The sender holds valid and all payload fields stable until that edge.
// The receiver may raise or drop ready at any time.
//
// Signals: valid, ready, read_enable, write_enable, addr[ADDR_W], data[DATA_W],
//          id[ID_W]. Result streams use valid/ready/data/id only.
// Modports: in  - receiving side (ready is an output)
//           out - sending side  (ready is an input)
// -----------------------------------------------------------------------------
interface std_mem_intf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              valid;
  logic              ready;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [ID_W-1:0]   id;

  modport in  (input  valid, read_enable, write_enable, addr, data, id,
               output ready);
  modport out (output valid, read_enable, write_enable, addr, data, id,
               input  ready);
endinterface

// File: rtl/std_mem_arbiter.sv
// -----------------------------------------------------------------------------
// std_mem_arbiter
//
// Shares one single-cycle memory command/result port pair among
// NUM_REQUESTERS requesters. Commands are arbitrated round-robin into a
// registered command output. Each accepted read pushes the winning requester
// index into an in-order tag FIFO; the FIFO head steers each memory result
// back to its requester. Writes produce no result and are not tracked.
//
// Handshake (all interfaces): transfer on a clk edge with valid && ready;
// the sender keeps valid and payload stable until the transfer.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   command_in[N]   requester commands          (std_mem_intf.in)
//   result_out[N]   per-requester read results  (std_mem_intf.out)
//   command_out     arbitrated command stream   (std_mem_intf.out)
//   result_in       in-order memory results     (std_mem_intf.in)
//   dbg_tag_count   registered tag FIFO occupancy
//   dbg_rr_ptr      round-robin pointer (0 in fixed-priority builds)
//
// Build option: define STD_MEM_ARBITER_FIXED_PRIORITY_EN for fixed priority
// (lowest index wins, no pointer register; requester 0 can starve others).
// -----------------------------------------------------------------------------
module std_mem_arbiter #(
  parameter int NUM_REQUESTERS    = 2,
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int ADDR_W            = 8,
  parameter int DATA_W            = 32,
  parameter int ID_W              = 4,
  localparam int IDX_W            = $clog2(NUM_REQUESTERS),
  localparam int PTR_W            = $clog2(OUTSTANDING_DEPTH),
  localparam int CNT_W            = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  std_mem_intf.in          command_in [NUM_REQUESTERS],
  std_mem_intf.out         result_out [NUM_REQUESTERS],
  std_mem_intf.out         command_out,
  std_mem_intf.in          result_in,
  output logic [CNT_W-1:0] dbg_tag_count,
  output logic [IDX_W-1:0] dbg_rr_ptr
);

  // Flattened requester-side views of the interface arrays.
  logic [NUM_REQUESTERS-1:0] req_valid;
  logic [NUM_REQUESTERS-1:0] req_re;
  logic [NUM_REQUESTERS-1:0] req_we;
  logic [NUM_REQUESTERS-1:0] req_ready;
  logic [NUM_REQUESTERS-1:0] res_ready;
  logic [NUM_REQUESTERS-1:0] res_valid;
  logic [ADDR_W-1:0]         req_addr [NUM_REQUESTERS];
  logic [DATA_W-1:0]         req_data [NUM_REQUESTERS];
  logic [ID_W-1:0]           req_id   [NUM_REQUESTERS];

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_req
    if ($bits(command_in[g].addr) != ADDR_W || $bits(command_in[g].data) != DATA_W ||
        $bits(command_in[g].id) != ID_W || $bits(result_out[g].data) != DATA_W ||
        $bits(result_out[g].id) != ID_W) begin : g_bad_width
      $error("std_mem_arbiter: requester interface width mismatch");
    end
    assign req_valid[g]               = command_in[g].valid;
    assign req_re[g]                  = command_in[g].read_enable;
    assign req_we[g]                  = command_in[g].write_enable;
    assign req_addr[g]                = command_in[g].addr;
    assign req_data[g]                = command_in[g].data;
    assign req_id[g]                  = command_in[g].id;
    assign command_in[g].ready        = req_ready[g];
    assign result_out[g].valid        = res_valid[g];
    assign result_out[g].data         = result_in.data;
    assign result_out[g].id           = result_in.id;
    assign result_out[g].read_enable  = 1'b0;
    assign result_out[g].write_enable = 1'b0;
    assign result_out[g].addr         = '0;
    assign res_ready[g]               = result_out[g].ready;
  end

  if ($bits(command_out.addr) != ADDR_W || $bits(command_out.data) != DATA_W ||
      $bits(command_out.id) != ID_W || $bits(result_in.data) != DATA_W ||
      $bits(result_in.id) != ID_W) begin : g_bad_width_mem
    $error("std_mem_arbiter: memory interface width mismatch");
  end

  // Result-side command fields carry nothing for a read-only result stream.
  logic unused_result_fields;
  assign unused_result_fields = ^{result_in.read_enable, result_in.write_enable, result_in.addr};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_re_q, cmd_re_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [ID_W-1:0]   cmd_id_q, cmd_id_d;

  logic [IDX_W-1:0]  tag_q [OUTSTANDING_DEPTH];
  logic [IDX_W-1:0]  tag_d [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                      tag_full;
  logic                      fifo_empty;
  logic [NUM_REQUESTERS-1:0] eligible;
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic                      cmd_can_load;
  logic                      accept;
  logic                      push;
  logic                      pop;

  // Eligibility uses the registered count only, so a pop in the same cycle
  // never unblocks a read and result-side ready cannot reach command_in ready.
  assign tag_full     = (count_q == CNT_W'(OUTSTANDING_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign eligible     = req_valid & ~(req_re & {NUM_REQUESTERS{tag_full}});
  assign cmd_can_load = !cmd_valid_q || command_out.ready;
  assign accept       = win_found && cmd_can_load && !rst;
  assign push         = accept && req_re[win_idx];

`ifdef STD_MEM_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (!win_found && eligible[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  assign dbg_rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Scan from the pointer, wrapping modulo NUM_REQUESTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      int cand;
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (win_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign dbg_rr_ptr = rr_ptr_q;
`endif

  always_comb begin
    req_ready          = '0;
    req_ready[win_idx] = accept;
  end

  // ---------------------------------------------------------------------------
  // Command register
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_re_d    = cmd_re_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_id_d    = cmd_id_q;
    if (accept) begin
      cmd_valid_d = 1'b1;
      cmd_re_d    = req_re[win_idx];
      cmd_we_d    = req_we[win_idx];
      cmd_addr_d  = req_addr[win_idx];
      cmd_data_d  = req_data[win_idx];
      cmd_id_d    = req_id[win_idx];
    end else if (command_out.ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  assign command_out.valid        = cmd_valid_q;
  assign command_out.read_enable  = cmd_re_q;
  assign command_out.write_enable = cmd_we_q;
  assign command_out.addr         = cmd_addr_q;
  assign command_out.data         = cmd_data_q;
  assign command_out.id           = cmd_id_q;

  // ---------------------------------------------------------------------------
  // Tag FIFO and result routing
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] head;
  logic             res_in_ready;

  assign head = tag_q[rd_ptr_q];

  // With no tag the result has no owner: accept and drop it.
  always_comb begin
    res_valid    = '0;
    res_in_ready = 1'b1;
    if (!fifo_empty) begin
      res_valid[head] = result_in.valid;
      res_in_ready    = res_ready[head];
    end
  end

  assign result_in.ready = res_in_ready;
  assign pop             = result_in.valid && res_in_ready && !fifo_empty;

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push) tag_d[wr_ptr_q] = win_idx;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  assign dbg_tag_count = count_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload and tag storage need no reset; they are qualified by valid/count.
  always_ff @(posedge clk) begin
    cmd_re_q   <= cmd_re_d;
    cmd_we_q   <= cmd_we_d;
    cmd_addr_q <= cmd_addr_d;
    cmd_data_q <= cmd_data_d;
    cmd_id_q   <= cmd_id_d;
    tag_q      <= tag_d;
  end

`ifndef SYNTHESIS
  // A result with no outstanding read indicates a broken memory or reset skew.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(result_in.valid && fifo_empty));
    end
  end
`endif

endmodule
